mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide responder for the EX stage. It accepts a multiply/divide request, presented as `funct` plus operands, and computes the result over several cycles. It then presents a 64-bit `{hi, lo}` result with a done flag, which the EX stage uses to release its stall and to drive the HI/LO write. It sits beside EX and returns its result directly to it.

## Interface
Parameters:
- `DIV_CYCLES`, 32: radix-2 iteration count; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `funct`  in  6  operation code; compared against the `funct.v` macros `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT2_MUL`, `FUNCT2_MADD`, `FUNCT2_MADDU`, `FUNCT2_MSUB`, `FUNCT2_MSUBU`
- `operand_1`  in  32  multiplicand or dividend
- `operand_2`  in  32  multiplier or divisor
- `hi_in`, `lo_in`  in  32 each  current HI/LO, accumulator base for MADD/MSUB
- `flush`  in  1  cancel the in-flight operation (exception or pipeline flush)
- `hold`  in  1  pipeline stalled by another source; keep the DONE result presented
- `busy`  out  1  an operation is computing
- `mult_div_done_flag`  out  1  `mult_div_result` is valid this cycle
- `mult_div_result`  out  64  `{hi, lo}`: product, accumulated value, or `{remainder, quotient}`

## Operation
- States: IDLE, MUL, DIV, DONE.
- Priority on every edge: `rst` > `flush` > normal transitions.
- Reset or flush:
  - state goes to IDLE;
  - `busy`, `mult_div_done_flag` and `mult_div_result` all go to 0.
- Start condition: state is IDLE, `funct` is one of the nine operations, and `flush` is 0.
- Start cycle actions:
  - latch `operand_1`, `operand_2`, `hi_in`, `lo_in` and the op;
  - for signed ops, latch magnitudes and result signs;
  - operand changes after the start cycle are ignored.
- IDLE to MUL: taken for MULT, MULTU, MUL, MADD(U), MSUB(U).
- IDLE to DIV: taken for DIV and DIVU with a nonzero divisor.
- IDLE to DONE: taken for DIV or DIVU with divisor 0. The result is `{operand_1, 32'hFFFFFFFF}`.
- MUL: computes the 64-bit product in one cycle, then goes to DONE.
  - MULT, MUL, MADD and MSUB are signed; the others are unsigned.
  - MADD(U) result: `{hi,lo} + product`.
  - MSUB(U) result: `{hi,lo} - product`.
  - All results wrap modulo 2^64.
  - For MUL, the full product is presented; the consumer uses `[31:0]`.
- DIV: restoring radix-2 division, one quotient bit per cycle, with a 5-bit iteration counter.
  - After 32 iterations, apply sign correction and go to DONE.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - `0x80000000 / -1` gives quotient `0x80000000`, remainder 0.
- DONE:
  - `mult_div_done_flag` is 1 and the result is stable.
  - If `hold` is 1, stay in DONE with no restart, even though `funct` still matches.
  - If `hold` is 0, go to IDLE.
- The result register keeps its last value in IDLE. Consumers qualify it with the done flag only.

## Timing
- Cycle 0 is the start cycle; `busy` is 1 from cycle 1 until the DONE cycle.
- Multiply class: `mult_div_done_flag` rises in cycle 2.
- Divide: `mult_div_done_flag` rises in cycle 33.
- Divide by zero: `mult_div_done_flag` rises in cycle 1.
- Done is deasserted in the cycle after DONE exits. A new start may occur in that same cycle; there is no dead cycle between back-to-back ops.
- `busy` is 0 in IDLE and DONE.
- Flush asserted in cycle N clears done/busy/result in cycle N+1, even while in DONE.
- Reset asserted mid-operation: all outputs are 0 the next cycle and no partial result is presented.

## Test plan
- MULT `0xFFFFFFFE`×`3`: done in cycle 2 with result `64'hFFFFFFFF_FFFFFFFA`. MULTU with the same operands gives `64'h00000002_FFFFFFFA`.
- DIV `0xFFFFFFF9`/`2`: done in cycle 33, busy 1 for cycles 1–32, result `{32'hFFFFFFFF, 32'hFFFFFFFD}`. DIVU `100`/`7` gives `{32'd2, 32'd14}`.
- DIVU `5`/`0`: done in cycle 1 with result `{32'd5, 32'hFFFFFFFF}`. DIV `0x80000000`/`0xFFFFFFFF` gives `{32'd0, 32'h80000000}`.
- MADD with `hi_in=0`, `lo_in=0xFFFFFFFF`, operands 2×3: result `{32'h1, 32'h5}`. MSUB with HI/LO=0, operands 1×1: result `64'hFFFFFFFF_FFFFFFFF`.
- Flush in cycle 10 of a DIV: done and busy are 0 in cycle 11. A DIVU `9`/`4` started in cycle 12 completes in cycle 45 with `{32'd1, 32'd2}`.
- `hold`=1 for 3 cycles in DONE: done stays 1 and the result is unchanged, with no restart. When `hold` drops, done is 0 the next cycle. A `rst` pulse mid-divide gives all outputs 0 one cycle later.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide responder for EX; one-cycle multiply,
// 32-cycle restoring divide, result held in DONE while the pipeline is held.
module mult_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        hold,
    output logic        busy,
    output logic        mult_div_done_flag,
    output logic [63:0] mult_div_result
);
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1b;
    localparam logic [5:0] FUNCT2_MADD  = 6'h00;
    localparam logic [5:0] FUNCT2_MADDU = 6'h01;
    localparam logic [5:0] FUNCT2_MUL   = 6'h02;
    localparam logic [5:0] FUNCT2_MSUB  = 6'h04;
    localparam logic [5:0] FUNCT2_MSUBU = 6'h05;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state;

    logic [31:0] a, b, rem;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        neg_q, neg_r, acc_en, sub;

    logic        is_div, is_sub, is_acc, is_signed, valid_op, ge;
    logic [31:0] mag_1, mag_2, rem_n, quo_n;
    logic [32:0] r_sh;
    logic [63:0] prod, prod_s, mul_res;

    // Operands are kept as magnitudes; a doubles as the dividend/quotient shift register.
    always_comb begin
        is_div    = funct == FUNCT_DIV || funct == FUNCT_DIVU;
        is_sub    = funct == FUNCT2_MSUB || funct == FUNCT2_MSUBU;
        is_acc    = is_sub || funct == FUNCT2_MADD || funct == FUNCT2_MADDU;
        is_signed = funct == FUNCT_MULT || funct == FUNCT2_MUL || funct == FUNCT2_MADD
                    || funct == FUNCT2_MSUB || funct == FUNCT_DIV;
        valid_op  = is_div || is_acc || funct == FUNCT_MULT || funct == FUNCT_MULTU
                    || funct == FUNCT2_MUL;
        mag_1     = (is_signed && operand_1[31]) ? -operand_1 : operand_1;
        mag_2     = (is_signed && operand_2[31]) ? -operand_2 : operand_2;
        r_sh      = {rem, a[31]};
        ge        = r_sh >= {1'b0, b};
        rem_n     = ge ? 32'(r_sh - {1'b0, b}) : r_sh[31:0];
        quo_n     = {a[30:0], ge};
        prod      = {32'b0, a} * {32'b0, b};
        prod_s    = neg_q ? -prod : prod;
        mul_res   = acc_en ? (sub ? acc - prod_s : acc + prod_s) : prod_s;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state              <= IDLE;
            busy               <= 1'b0;
            mult_div_done_flag <= 1'b0;
            mult_div_result    <= '0;
            cnt                <= '0;
        end else begin
            case (state)
                IDLE: if (valid_op) begin
                    a      <= mag_1;
                    b      <= mag_2;
                    acc    <= {hi_in, lo_in};
                    rem    <= '0;
                    cnt    <= '0;
                    neg_q  <= is_signed && (operand_1[31] ^ operand_2[31]);
                    neg_r  <= is_signed && operand_1[31];
                    acc_en <= is_acc;
                    sub    <= is_sub;
                    if (is_div && operand_2 == 32'd0) begin
                        state              <= DONE;
                        mult_div_done_flag <= 1'b1;
                        mult_div_result    <= {operand_1, 32'hFFFFFFFF};
                    end else begin
                        state <= is_div ? DIV : MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    state              <= DONE;
                    busy               <= 1'b0;
                    mult_div_done_flag <= 1'b1;
                    mult_div_result    <= mul_res;
                end
                DIV: begin
                    a   <= quo_n;
                    rem <= rem_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_CYCLES - 1)) begin
                        state              <= DONE;
                        busy               <= 1'b0;
                        mult_div_done_flag <= 1'b1;
                        mult_div_result    <= {neg_r ? -rem_n : rem_n, neg_q ? -quo_n : quo_n};
                    end
                end
                DONE: if (!hold) begin
                    state              <= IDLE;
                    mult_div_done_flag <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random ops checked against an arithmetic reference model.
module tb_mult_div_unit;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;
    localparam logic [5:0] F_MUL   = 6'h02;
    localparam logic [5:0] F_MSUB  = 6'h04;
    localparam logic [5:0] F_MSUBU = 6'h05;
    localparam logic [5:0] F_NONE  = 6'h3f;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, hold = 1'b0;
    logic [5:0]  funct = F_NONE;
    logic [31:0] operand_1 = '0, operand_2 = '0, hi_in = '0, lo_in = '0;
    logic        busy, done;
    logic [63:0] result;
    int checks = 0, errors = 0;
    logic [5:0] ops [9] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MADD, F_MADDU, F_MUL, F_MSUB, F_MSUBU};

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .funct(funct), .operand_1(operand_1), .operand_2(operand_2),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .hold(hold),
        .busy(busy), .mult_div_done_flag(done), .mult_div_result(result)
    );

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, y, h, l);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, ps, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        ps = 64'(sx * sy);
        pu = ux * uy;
        case (f)
            F_MULT, F_MUL: return ps;
            F_MULTU:       return pu;
            F_MADD:        return {h, l} + ps;
            F_MADDU:       return {h, l} + pu;
            F_MSUB:        return {h, l} - ps;
            F_MSUBU:       return {h, l} - pu;
            F_DIV: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            F_DIVU:        return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default:       return 64'd0;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] f, input logic [31:0] y);
        if (f == F_DIV || f == F_DIVU) return (y == 0) ? 1 : 33;
        return 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts in the current cycle (cycle 0); returns in the first IDLE cycle after DONE exits.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, y, h, l, input int hold_n);
        logic [63:0] exp;
        int lat;
        exp = model(f, x, y, h, l);
        lat = latency(f, y);
        funct = f; operand_1 = x; operand_2 = y; hi_in = h; lo_in = l;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                funct = F_NONE;
                operand_1 = $urandom; operand_2 = $urandom; hi_in = $urandom; lo_in = $urandom;
            end
            chk("busy", {63'b0, busy}, 64'(k < lat));
            chk("done", {63'b0, done}, 64'(k == lat));
        end
        chk("result", result, exp);
        hold = hold_n > 0;
        if (hold_n > 0) funct = f;
        for (int j = 1; j <= hold_n; j++) begin
            @(posedge clk); #1;
            chk("hold_done", {63'b0, done}, 64'd1);
            chk("hold_busy", {63'b0, busy}, 64'd0);
            chk("hold_result", result, exp);
            if (j == hold_n) begin
                hold = 1'b0;
                funct = F_NONE;
            end
        end
        @(posedge clk); #1;
        chk("exit_done", {63'b0, done}, 64'd0);
        chk("exit_busy", {63'b0, busy}, 64'd0);
        chk("kept_result", result, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;

        run_op(F_MULT,  32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 0);
        chk("plan_mult", result, 64'hFFFFFFFF_FFFFFFFA);
        run_op(F_MULTU, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 0);
        chk("plan_multu", result, 64'h00000002_FFFFFFFA);
        run_op(F_DIV,   32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 0);
        chk("plan_div", result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op(F_DIVU,  32'd100, 32'd7, 32'd0, 32'd0, 0);
        chk("plan_divu", result, {32'd2, 32'd14});
        run_op(F_DIVU,  32'd5, 32'd0, 32'd0, 32'd0, 0);
        chk("plan_div0", result, {32'd5, 32'hFFFFFFFF});
        run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 0);
        chk("plan_ovf", result, {32'd0, 32'h80000000});
        run_op(F_MADD,  32'd2, 32'd3, 32'd0, 32'hFFFFFFFF, 0);
        chk("plan_madd", result, {32'h1, 32'h5});
        run_op(F_MSUB,  32'd1, 32'd1, 32'd0, 32'd0, 3);
        chk("plan_msub", result, 64'hFFFFFFFF_FFFFFFFF);

        // flush in cycle 10 of a divide
        funct = F_DIV; operand_1 = 32'h12345678; operand_2 = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            funct = F_NONE;
            chk("pre_flush_busy", {63'b0, busy}, 64'd1);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done", {63'b0, done}, 64'd0);
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_result", result, 64'd0);
        @(posedge clk); #1;
        run_op(F_DIVU, 32'd9, 32'd4, 32'd0, 32'd0, 0);
        chk("plan_after_flush", result, {32'd1, 32'd2});

        // flush while held in DONE
        funct = F_MULTU; operand_1 = 32'd3; operand_2 = 32'd5;
        @(posedge clk); #1;
        funct = F_NONE;
        @(posedge clk); #1;
        chk("done_before_flush", {63'b0, done}, 64'd1);
        hold = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        hold = 1'b0; flush = 1'b0;
        chk("flush_in_done", {63'b0, done}, 64'd0);
        chk("flush_in_done_result", result, 64'd0);

        // reset mid-divide
        funct = F_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (5) begin
            @(posedge clk); #1;
            funct = F_NONE;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_result", result, 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            logic [31:0] x, y;
            int sel;
            f = ops[$urandom_range(0, 8)];
            sel = $urandom_range(0, 5);
            x = (sel == 3) ? 32'h80000000 : $urandom;
            y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(f, x, y, $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
